icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the instruction-fetch unit and the memory controller.
//  Serves one 32-bit instruction word per fetch request; on a miss, requests a full line from the controller's
//  instruction port, installs the returned line, then answers. Rollback discards the pending answer, never the fill.
// PARAMETERS
//  LINE_BYTES  16  bytes per line; power of 2, >=4; equals the controller's instruction burst length
//  INDEX_WID   4   index bits; line count = 2**INDEX_WID
//  ADDR_W      32  address width
// PORTS
//  clk        in   1                  clock, single clock domain
//  rst        in   1                  reset, synchronous, active-high
//  rdy        in   1                  global enable; low = freeze all state and outputs
//  rollback   in   1                  flush pending fetch response
//  ifu_en     in   1                  fetch request; held with ifu_pc until ifu_valid or rollback
//  ifu_pc     in   ADDR_W             fetch address; bits [1:0] ignored
//  ifu_valid  out  1                  one-cycle pulse: ifu_inst is the word at the accepted pc
//  ifu_inst   out  32                 instruction word, little-endian from line bytes
//  mem_en     out  1                  line-fill request to memory controller
//  mem_pc     out  ADDR_W             line-aligned fill address (offset bits zero)
//  mem_done   in   1                  one-cycle pulse: mem_data holds the full line
//  mem_data   in   LINE_BYTES*8       line data; byte i at bits [8i+7:8i]
// BEHAVIOUR
//  - Address split: OFF=log2(LINE_BYTES) bits offset, next INDEX_WID bits index, remaining upper bits tag.
//  - Storage: valid, tag, and data per line. Data is written only on mem_done.
//  - Reset: all valid bits cleared; state IDLE; ifu_valid=0, ifu_inst=0, mem_en=0, mem_pc=0. Reset
//    mid-fill abandons the fill; a later mem_done is ignored because state is IDLE.
//  - rdy=0: no register changes; outputs hold their values.
//  - FSM with three states: IDLE, MISS, RESP.
//    - IDLE, ifu_en=1, rollback=0, hit: next cycle ifu_valid=1 with the word; stay IDLE.
//      Hit latency is 1 cycle.
//    - IDLE, ifu_en=1, rollback=0, miss: latch line address; mem_en=1 and mem_pc=line address from the
//      next cycle; go to MISS.
//    - MISS: hold mem_en and mem_pc steady until mem_done.
//      On mem_done: write data, tag, valid=1; drop mem_en in the same edge; go to RESP.
//    - RESP: drive ifu_valid=1 with the word selected by the latched offset, unless killed. Go to IDLE.
//      Miss latency from mem_done to ifu_valid is 1 cycle.
//  - While ifu_valid is pulsing, the request is not re-sampled. The cycle after any ifu_valid, IDLE ignores
//    ifu_en, so a held request is never served twice.
//  - rollback:
//    - In IDLE, it suppresses acceptance that cycle and clears a pending ifu_valid pulse to 0.
//    - In MISS, it sets a kill flag. The fill still completes and installs the line. RESP then emits
//      no ifu_valid, and the kill flag is cleared on entry to IDLE.
//  - Requests with ifu_en in MISS or RESP are not sampled; no queueing.
//  - mem_done outside MISS is ignored.
//  - A word never straddles lines, because LINE_BYTES is a multiple of 4.
//  - ifu_inst holds its last value when ifu_valid=0.
// TESTING
//  1. Cold miss: reset, then ifu_en=1, pc=0x0000_0008.
//     -> mem_en=1 with mem_pc=0x0 next cycle. Return mem_done with line bytes 0x00..0x0F.
//     -> one cycle later, ifu_valid=1 and ifu_inst=0x0B0A0908; mem_en=0.
//  2. Hit: after test 1, pc=0x0000_000C.
//     -> ifu_valid=1 the next cycle with 0x0F0E0D0C; mem_en stays 0 throughout.
//  3. Conflict: pc=0x0000_0100 maps to index 0 with tag 1 -> miss, mem_pc=0x100.
//     After the fill, pc=0x0 misses again.
//  4. Rollback during MISS: assert rollback for 1 cycle before mem_done.
//     -> the line is installed, but no ifu_valid pulse. A re-request of the same pc then hits with 1-cycle latency.
//  5. rdy=0 for 3 cycles in MISS with mem_done absent.
//     -> mem_en, mem_pc, and state are unchanged; behaviour resumes normally after rdy=1.
//  6. Reset asserted in MISS, with mem_done arriving the next cycle.
//     -> the line is not installed, ifu_valid=0, mem_en=0, and a later fetch to the same pc misses.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle for the instruction cache.
// The slave view belongs to the cache; the master view drives it from outside.
interface icache_if #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_W     = 32
);
  logic                    ifu_en;
  logic [ADDR_W-1:0]       ifu_pc;
  logic                    ifu_valid;
  logic [31:0]             ifu_inst;
  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_pc;
  logic                    mem_done;
  logic [LINE_BYTES*8-1:0] mem_data;

  modport slave (
    input  ifu_en, ifu_pc, mem_done, mem_data,
    output ifu_valid, ifu_inst, mem_en, mem_pc
  );

  modport master (
    output ifu_en, ifu_pc, mem_done, mem_data,
    input  ifu_valid, ifu_inst, mem_en, mem_pc
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: serves one word per fetch and
// fills a whole line from the memory controller on a miss.
module icache #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned INDEX_WID  = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    rollback,
  icache_if.slave bus
);
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned LINES  = 1 << INDEX_WID;
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - INDEX_WID;
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [ADDR_W-1:0]   mem_pc_q, mem_pc_d;
  logic                mem_en_q, mem_en_d;
  logic                ifu_valid_q, ifu_valid_d;
  logic                valid_dly_q, valid_dly_d;
  logic [31:0]         ifu_inst_q, ifu_inst_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                kill_q, kill_d;
  logic                fill_we;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [LINE_W-1:0]   data_mem [LINES];

  logic [INDEX_WID-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]     req_tag, fill_tag;
  logic                 hit;

  // Little-endian word at the word-aligned byte offset within a line.
  function automatic logic [31:0] get_word(logic [LINE_W-1:0] line, logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] boff;
    boff = off & ~OFF_W'(3);
    return 32'(line >> (32'(boff) * 32'd8));
  endfunction

  assign req_idx  = bus.ifu_pc[OFF_W +: INDEX_WID];
  assign req_tag  = bus.ifu_pc[ADDR_W-1 -: TAG_W];
  assign fill_idx = mem_pc_q[OFF_W +: INDEX_WID];
  assign fill_tag = mem_pc_q[ADDR_W-1 -: TAG_W];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    mem_pc_d    = mem_pc_q;
    mem_en_d    = mem_en_q;
    ifu_valid_d = 1'b0;
    valid_dly_d = ifu_valid_q;
    ifu_inst_d  = ifu_inst_q;
    off_d       = off_q;
    kill_d      = kill_q;
    fill_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A request still held across a pulse or the cycle after it is already served.
        if (bus.ifu_en && !rollback && !ifu_valid_q && !valid_dly_q) begin
          if (hit) begin
            ifu_valid_d = 1'b1;
            ifu_inst_d  = get_word(data_mem[req_idx], bus.ifu_pc[OFF_W-1:0]);
          end else begin
            mem_en_d = 1'b1;
            mem_pc_d = {bus.ifu_pc[ADDR_W-1:OFF_W], OFF_W'(0)};
            off_d    = bus.ifu_pc[OFF_W-1:0];
            state_d  = MISS;
          end
        end
      end
      MISS: begin
        if (rollback) kill_d = 1'b1;
        if (bus.mem_done) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          mem_en_d          = 1'b0;
          state_d           = RESP;
          // Answer straight from the returning line so the response lands one cycle after mem_done.
          if (!kill_q && !rollback) begin
            ifu_valid_d = 1'b1;
            ifu_inst_d  = get_word(bus.mem_data, off_q);
          end
        end
      end
      RESP: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_pc_q    <= '0;
      mem_en_q    <= 1'b0;
      ifu_valid_q <= 1'b0;
      valid_dly_q <= 1'b0;
      ifu_inst_q  <= '0;
      off_q       <= '0;
      kill_q      <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_pc_q    <= mem_pc_d;
      mem_en_q    <= mem_en_d;
      ifu_valid_q <= ifu_valid_d;
      valid_dly_q <= valid_dly_d;
      ifu_inst_q  <= ifu_inst_d;
      off_q       <= off_d;
      kill_q      <= kill_d;
    end
  end

  // Tag and data arrays need no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mem_data;
    end
  end

  assign bus.ifu_valid = ifu_valid_q;
  assign bus.ifu_inst  = ifu_inst_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_pc    = mem_pc_q;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a line-level cache model sets the expected outputs
// cycle by cycle and one negedge process compares them against the DUT.
module tb_icache;
  logic clk = 1'b0;
  logic rst, rdy, rollback;

  icache_if #(.LINE_BYTES(16), .ADDR_W(32)) bus ();

  icache #(.LINE_BYTES(16), .INDEX_WID(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  logic        exp_valid;
  logic [31:0] exp_inst;
  logic        exp_mem_en;
  logic [31:0] exp_mem_pc;

  // Cache model: which line address each index holds.
  bit          m_valid [16];
  logic [31:0] m_la    [16];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("ifu_valid", 32'(bus.ifu_valid), 32'(exp_valid));
      cmp("ifu_inst",  bus.ifu_inst,       exp_inst);
      cmp("mem_en",    32'(bus.mem_en),    32'(exp_mem_en));
      cmp("mem_pc",    bus.mem_pc,         exp_mem_pc);
    end
  end

  // Memory contents: byte i of the line at address la.
  function automatic logic [7:0] line_byte(input logic [31:0] la, input int i);
    logic [7:0] a, b;
    a = la[7:0] + 8'(i);
    b = la[15:8] * 8'h37;
    return a ^ b;
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = line_byte(la, i);
    return l;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] pc);
    logic [31:0] la;
    int o;
    la = pc & ~32'hF;
    o  = int'(pc[3:2]) * 4;
    return {line_byte(la, o+3), line_byte(la, o+2), line_byte(la, o+1), line_byte(la, o)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_la[i]    = '0;
    end
    exp_valid  = 1'b0;
    exp_inst   = '0;
    exp_mem_en = 1'b0;
    exp_mem_pc = '0;
  endtask

  // One fetch. rb: rollback one cycle before mem_done. stall: rdy low 3 cycles in MISS.
  task automatic fetch(input logic [31:0] pc, input bit rb, input bit stall,
                       input bit use_lit, input logic [31:0] lit);
    logic [31:0] la, w;
    int idx;
    bit hit;
    la  = pc & ~32'hF;
    idx = int'(pc[7:4]);
    hit = m_valid[idx] && (m_la[idx] == la);
    w   = model_word(pc);
    bus.ifu_en = 1'b1;
    bus.ifu_pc = pc;
    step();
    if (hit) begin
      exp_valid = 1'b1;
      exp_inst  = w;
      if (use_lit) cmp("hit_word_literal", bus.ifu_inst, lit);
      step();
      exp_valid = 1'b0;
      step();
    end else begin
      exp_mem_en = 1'b1;
      exp_mem_pc = la;
      if (stall) begin
        rdy = 1'b0;
        repeat (3) step();
        rdy = 1'b1;
      end
      step();
      if (rb) begin
        rollback = 1'b1;
        step();
        rollback   = 1'b0;
        bus.ifu_en = 1'b0;
      end
      bus.mem_done = 1'b1;
      bus.mem_data = make_line(la);
      step();
      bus.mem_done = 1'b0;
      bus.mem_data = '0;
      m_valid[idx] = 1'b1;
      m_la[idx]    = la;
      exp_mem_en   = 1'b0;
      if (!rb) begin
        exp_valid = 1'b1;
        exp_inst  = w;
        if (use_lit) cmp("miss_word_literal", bus.ifu_inst, lit);
      end
      step();
      exp_valid = 1'b0;
      step();
    end
    bus.ifu_en = 1'b0;
    step();
  endtask

  initial begin
    rst          = 1'b1;
    rdy          = 1'b1;
    rollback     = 1'b0;
    bus.ifu_en   = 1'b0;
    bus.ifu_pc   = '0;
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    model_clear();
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Cold miss, then hit in the same line.
    fetch(32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0B0A_0908);
    fetch(32'h0000_000C, 1'b0, 1'b0, 1'b1, 32'h0F0E_0D0C);

    // Conflict on index 0, then a different index.
    fetch(32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h3435_3637);
    fetch(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0302_0100);
    fetch(32'h0000_1238, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(32'h0000_1230, 1'b0, 1'b0, 1'b0, 32'h0);

    // Rollback in MISS: line installed, no answer; re-request hits.
    fetch(32'h0000_0020, 1'b1, 1'b0, 1'b0, 32'h0);
    fetch(32'h0000_0020, 1'b0, 1'b0, 1'b1, 32'h2322_2120);

    // rdy low for 3 cycles while waiting for the fill.
    fetch(32'h0000_0044, 1'b0, 1'b1, 1'b1, 32'h4746_4544);

    // Rollback in IDLE suppresses acceptance of a hit.
    bus.ifu_en = 1'b1;
    bus.ifu_pc = 32'h0000_0004;
    rollback   = 1'b1;
    step();
    rollback   = 1'b0;
    bus.ifu_en = 1'b0;
    step();
    step();

    // Reset during MISS with mem_done arriving just after.
    bus.ifu_en = 1'b1;
    bus.ifu_pc = 32'h0000_0058;
    step();
    exp_mem_en = 1'b1;
    exp_mem_pc = 32'h0000_0050;
    step();
    rst = 1'b1;
    step();
    rst          = 1'b0;
    bus.ifu_en   = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_data = make_line(32'h0000_0050);
    model_clear();
    step();
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    step();
    fetch(32'h0000_0058, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0B0A_0908);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
